// File: rtl/imem_sib_pkg.sv
// Shared types and constants for the instruction-memory SIB arbiter slice.
package imem_sib_pkg;

    localparam int SIB_ADDR_W = 16;
    localparam int SIB_DATA_W = 32;
    localparam int SIB_MASK_W = SIB_DATA_W / 8;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        ACCESS_ERR
    } arb_state_t;

endpackage

// File: rtl/imem_sib_arbiter_rr_grant.sv
// Two-requester round-robin grant; remembers the last owner so that
// contention always goes to the master that did not win last time.
module sib_rr_grant
    import imem_sib_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic update,
    output logic grant,
    output logic owner
);

    assign grant = (req0 && req1) ? ~owner : req1;

    // Resetting to M_DBG lets the CPU win the first contention.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner <= M_DBG;
        end else if (update) begin
            owner <= grant;
        end
    end

endmodule

// File: rtl/imem_sib_arbiter.sv
// Arbitrates CPU fetch (m0) and debug/loader (m1) onto the imem SIB port.
// Optional: IMEM_ARB_WRITE_PROTECT_EN rejects m0 writes with an error response.
module imem_sib_arbiter
    import imem_sib_pkg::*;
#(
    parameter int ADDR_W = SIB_ADDR_W,
    parameter int DATA_W = SIB_DATA_W,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_sib_addr,
    input  logic              m0_sib_sel,
    input  logic              m0_sib_enable,
    input  logic              m0_sib_write,
    input  logic [DATA_W-1:0] m0_sib_wdata,
    input  logic [MASK_W-1:0] m0_sib_mask,
    output logic [DATA_W-1:0] m0_sib_rdata,
    output logic              m0_sib_ready,
    output logic              m0_sib_resp,
    input  logic [ADDR_W-1:0] m1_sib_addr,
    input  logic              m1_sib_sel,
    input  logic              m1_sib_enable,
    input  logic              m1_sib_write,
    input  logic [DATA_W-1:0] m1_sib_wdata,
    input  logic [MASK_W-1:0] m1_sib_mask,
    output logic [DATA_W-1:0] m1_sib_rdata,
    output logic              m1_sib_ready,
    output logic              m1_sib_resp,
    output logic [ADDR_W-1:0] s_sib_addr,
    output logic              s_sib_sel,
    output logic              s_sib_enable,
    output logic              s_sib_write,
    output logic [DATA_W-1:0] s_sib_wdata,
    output logic [MASK_W-1:0] s_sib_mask,
    input  logic [DATA_W-1:0] s_sib_rdata,
    input  logic              s_sib_ready,
    input  logic              s_sib_resp,
    output logic              owner,
    output logic              busy
);

    arb_state_t state, state_next;
    logic       grant;
    logic       grant_update;
    logic       active;
    logic       done;
    logic       m0_done;
    logic       m1_done;
    logic       err_done;

    // Masters' own phase flags carry no information; phasing is generated here.
    logic unused_enables;
    assign unused_enables = m0_sib_enable ^ m1_sib_enable;

    sib_rr_grant u_grant (
        .clk    (clk),
        .reset  (reset),
        .req0   (m0_sib_sel),
        .req1   (m1_sib_sel),
        .update (grant_update),
        .grant  (grant),
        .owner  (owner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        grant_update = 1'b0;
        case (state)
            IDLE: begin
                if (m0_sib_sel || m1_sib_sel) begin
                    grant_update = 1'b1;
`ifdef IMEM_ARB_WRITE_PROTECT_EN
                    if (grant == M_CPU && m0_sib_write) begin
                        state_next = ACCESS_ERR;
                    end else begin
                        state_next = SETUP;
                    end
`else
                    state_next = SETUP;
`endif
                end
            end
            SETUP:      state_next = ACCESS;
            ACCESS:     if (s_sib_ready) state_next = IDLE;
            ACCESS_ERR: state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    assign active       = (state == SETUP) || (state == ACCESS);
    assign busy         = active;
    assign s_sib_sel    = active;
    assign s_sib_enable = (state == ACCESS);

    // Slave request fields follow the owner and are forced to zero when idle.
    always_comb begin
        s_sib_addr  = '0;
        s_sib_write = 1'b0;
        s_sib_wdata = '0;
        s_sib_mask  = '0;
        if (active) begin
            if (owner == M_DBG) begin
                s_sib_addr  = m1_sib_addr;
                s_sib_write = m1_sib_write;
                s_sib_wdata = m1_sib_wdata;
                s_sib_mask  = m1_sib_mask;
            end else begin
                s_sib_addr  = m0_sib_addr;
                s_sib_write = m0_sib_write;
                s_sib_wdata = m0_sib_wdata;
                s_sib_mask  = m0_sib_mask;
            end
        end
    end

    // A master that dropped sel mid-transfer gets nothing back.
    assign done     = (state == ACCESS) && s_sib_ready;
    assign m0_done  = done && (owner == M_CPU) && m0_sib_sel;
    assign m1_done  = done && (owner == M_DBG) && m1_sib_sel;
    assign err_done = (state == ACCESS_ERR) && m0_sib_sel;

    assign m0_sib_ready = m0_done || err_done;
    assign m0_sib_resp  = (m0_done && s_sib_resp) || err_done;
    assign m0_sib_rdata = m0_done ? s_sib_rdata : '0;
    assign m1_sib_ready = m1_done;
    assign m1_sib_resp  = m1_done && s_sib_resp;
    assign m1_sib_rdata = m1_done ? s_sib_rdata : '0;

endmodule

// File: tb/tb_imem_sib_arbiter.sv
// Self-checking bench for imem_sib_arbiter: directed transfers against a
// transaction-level model plus a small imem slave with programmable wait states.
module tb_imem_sib_arbiter;

    logic        clk;
    logic        reset;
    logic [15:0] m0_sib_addr, m1_sib_addr, s_sib_addr;
    logic        m0_sib_sel, m0_sib_enable, m0_sib_write;
    logic        m1_sib_sel, m1_sib_enable, m1_sib_write;
    logic [31:0] m0_sib_wdata, m1_sib_wdata, s_sib_wdata;
    logic [3:0]  m0_sib_mask, m1_sib_mask, s_sib_mask;
    logic [31:0] m0_sib_rdata, m1_sib_rdata, s_sib_rdata;
    logic        m0_sib_ready, m0_sib_resp, m1_sib_ready, m1_sib_resp;
    logic        s_sib_sel, s_sib_enable, s_sib_write, s_sib_ready, s_sib_resp;
    logic        owner, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    imem_sib_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_sib_addr(m0_sib_addr), .m0_sib_sel(m0_sib_sel), .m0_sib_enable(m0_sib_enable),
        .m0_sib_write(m0_sib_write), .m0_sib_wdata(m0_sib_wdata), .m0_sib_mask(m0_sib_mask),
        .m0_sib_rdata(m0_sib_rdata), .m0_sib_ready(m0_sib_ready), .m0_sib_resp(m0_sib_resp),
        .m1_sib_addr(m1_sib_addr), .m1_sib_sel(m1_sib_sel), .m1_sib_enable(m1_sib_enable),
        .m1_sib_write(m1_sib_write), .m1_sib_wdata(m1_sib_wdata), .m1_sib_mask(m1_sib_mask),
        .m1_sib_rdata(m1_sib_rdata), .m1_sib_ready(m1_sib_ready), .m1_sib_resp(m1_sib_resp),
        .s_sib_addr(s_sib_addr), .s_sib_sel(s_sib_sel), .s_sib_enable(s_sib_enable),
        .s_sib_write(s_sib_write), .s_sib_wdata(s_sib_wdata), .s_sib_mask(s_sib_mask),
        .s_sib_rdata(s_sib_rdata), .s_sib_ready(s_sib_ready), .s_sib_resp(s_sib_resp),
        .owner(owner), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // imem stand-in: 16 words, ready after wait_cfg access cycles.
    logic [31:0] mem [16];
    int          wait_cfg = 0;
    int          wait_cnt = 0;
    logic        resp_cfg = 1'b0;

    assign s_sib_ready = s_sib_sel && s_sib_enable && (wait_cnt == wait_cfg);
    assign s_sib_rdata = mem[s_sib_addr[5:2]];
    assign s_sib_resp  = s_sib_ready && resp_cfg;

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[4] <= 32'hDEADBEEF;
            mem[8] <= 32'hCAFEF00D;
            mem[2] <= 32'h0BADF00D;
            wait_cnt <= 0;
        end else begin
            if (s_sib_sel && s_sib_enable && !s_sib_ready) wait_cnt <= wait_cnt + 1;
            else wait_cnt <= 0;
            if (s_sib_ready && s_sib_write) begin
                for (int b = 0; b < 4; b++)
                    if (s_sib_mask[b]) mem[s_sib_addr[5:2]][8*b +: 8] <= s_sib_wdata[8*b +: 8];
            end
        end
    end

    // Transaction model: a granted transfer occupies 2+wait_cfg cycles after
    // the grant cycle; the response arrives in its last cycle.
    logic m_active = 1'b0;
    logic m_err    = 1'b0;
    logic m_owner  = 1'b1;
    int   m_age    = 0;
    logic rr_pick;
    assign rr_pick = (m0_sib_sel && m1_sib_sel) ? !m_owner : m1_sib_sel;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active <= 1'b0;
            m_err    <= 1'b0;
            m_owner  <= 1'b1;
            m_age    <= 0;
        end else if (m_err) begin
            m_err <= 1'b0;
        end else if (m_active) begin
            if (m_age >= 1 + wait_cfg) m_active <= 1'b0;
            else m_age <= m_age + 1;
        end else if (m0_sib_sel || m1_sib_sel) begin
            m_owner <= rr_pick;
            m_age   <= 0;
`ifdef IMEM_ARB_WRITE_PROTECT_EN
            if (!rr_pick && m0_sib_write) m_err <= 1'b1;
            else m_active <= 1'b1;
`else
            m_active <= 1'b1;
`endif
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        logic        done, m0_ok, m1_ok;
        logic [15:0] e_addr;
        logic [31:0] e_rdata;
        done   = m_active && (m_age == 1 + wait_cfg);
        e_addr = !m_active ? 16'h0 : (m_owner ? m1_sib_addr : m0_sib_addr);
        e_rdata = mem[e_addr[5:2]];
        m0_ok  = done && !m_owner && m0_sib_sel;
        m1_ok  = done && m_owner && m1_sib_sel;
        checkOutput("s_sel", s_sib_sel, m_active);
        checkOutput("s_enable", s_sib_enable, m_active && m_age >= 1);
        checkOutput("busy", busy, m_active);
        checkOutput("owner", owner, m_owner);
        checkOutput("s_addr", s_sib_addr, e_addr);
        checkOutput("s_write", s_sib_write, m_active && (m_owner ? m1_sib_write : m0_sib_write));
        checkOutput("s_wdata", s_sib_wdata, !m_active ? 32'h0 : (m_owner ? m1_sib_wdata : m0_sib_wdata));
        checkOutput("s_mask", s_sib_mask, !m_active ? 4'h0 : (m_owner ? m1_sib_mask : m0_sib_mask));
        checkOutput("m0_ready", m0_sib_ready, m0_ok || (m_err && m0_sib_sel));
        checkOutput("m0_resp", m0_sib_resp, (m0_ok && resp_cfg) || (m_err && m0_sib_sel));
        checkOutput("m0_rdata", m0_sib_rdata, m0_ok ? e_rdata : 32'h0);
        checkOutput("m1_ready", m1_sib_ready, m1_ok);
        checkOutput("m1_resp", m1_sib_resp, m1_ok && resp_cfg);
        checkOutput("m1_rdata", m1_sib_rdata, m1_ok ? e_rdata : 32'h0);
    end

    task automatic applyStimulus(input int master, input logic sel, input logic write,
                                 input logic [15:0] addr, input logic [31:0] wdata, input logic [3:0] mask);
        if (master == 0) begin
            m0_sib_sel = sel; m0_sib_write = write; m0_sib_addr = addr;
            m0_sib_wdata = wdata; m0_sib_mask = mask; m0_sib_enable = sel;
        end else begin
            m1_sib_sel = sel; m1_sib_write = write; m1_sib_addr = addr;
            m1_sib_wdata = wdata; m1_sib_mask = mask; m1_sib_enable = sel;
        end
    endtask

    task automatic waitReady(input int master, input int budget, output int took);
        took = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((master == 0) ? m0_sib_ready : m1_sib_ready) begin
                took = i;
                break;
            end
        end
        if (took < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout master %0d: no ready within %0d cycles", master, budget);
        end
    endtask

    initial begin
        int   took, en_cnt, n_rdy, drop_rdy;
        int   order [4];
        int   at [4];
        int   exp_order [4];
        logic sel_seen;
        exp_order = '{0, 1, 0, 1};

        reset = 1'b1;
        applyStimulus(0, 0, 0, 16'h0, 32'h0, 4'h0);
        applyStimulus(1, 0, 0, 16'h0, 32'h0, 4'h0);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_owner", owner, 1);
        checkOutput("rst_sel", s_sib_sel, 0);
        checkOutput("rst_m0_ready", m0_sib_ready, 0);
        @(posedge clk) #1 reset = 1'b1;

        // m0 zero-wait read
        @(posedge clk) #1 applyStimulus(0, 1, 0, 16'h0010, 32'h0, 4'hF);
        @(negedge clk);
        checkOutput("t1_idle_sel", s_sib_sel, 0);
        @(negedge clk);
        checkOutput("t1_setup_sel", s_sib_sel, 1);
        checkOutput("t1_setup_en", s_sib_enable, 0);
        @(negedge clk);
        checkOutput("t1_access_en", s_sib_enable, 1);
        checkOutput("t1_m0_ready", m0_sib_ready, 1);
        checkOutput("t1_m0_rdata", m0_sib_rdata, 32'hDEADBEEF);
        checkOutput("t1_m1_ready", m1_sib_ready, 0);
        @(posedge clk) #1 applyStimulus(0, 0, 0, 16'h0, 32'h0, 4'h0);

        // m1 write with 3 wait states
        wait_cfg = 3;
        applyStimulus(1, 1, 1, 16'h0004, 32'h12345678, 4'hF);
        en_cnt = 0;
        took = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_sib_enable) begin
                en_cnt++;
                checkOutput("t2_wdata", s_sib_wdata, 32'h12345678);
                checkOutput("t2_mask", s_sib_mask, 4'hF);
            end
            if (m1_sib_ready) begin
                took = i;
                checkOutput("t2_owner", owner, 1);
                break;
            end
        end
        checkOutput("t2_en_cycles", en_cnt, 4);
        checkOutput("t2_ready_seen", took >= 0, 1);
        @(posedge clk) #1 applyStimulus(1, 0, 0, 16'h0, 32'h0, 4'h0);
        wait_cfg = 0;
        checkOutput("t2_mem_written", mem[1], 32'h12345678);

        // continuous contention: alternate grants, m0 first
        @(posedge clk) #1;
        applyStimulus(0, 1, 0, 16'h0010, 32'h0, 4'hF);
        applyStimulus(1, 1, 0, 16'h0020, 32'h0, 4'hF);
        n_rdy = 0;
        for (int i = 0; i < 40 && n_rdy < 4; i++) begin
            @(negedge clk);
            if (m0_sib_ready) begin order[n_rdy] = 0; at[n_rdy] = cyc; n_rdy++; end
            else if (m1_sib_ready) begin order[n_rdy] = 1; at[n_rdy] = cyc; n_rdy++; end
        end
        @(posedge clk) #1;
        applyStimulus(0, 0, 0, 16'h0, 32'h0, 4'h0);
        applyStimulus(1, 0, 0, 16'h0, 32'h0, 4'h0);
        checkOutput("t4_count", n_rdy, 4);
        for (int i = 0; i < n_rdy; i++) begin
            checkOutput("t4_order", order[i], exp_order[i]);
            if (i > 0) checkOutput("t4_gap_ge3", (at[i] - at[i-1]) >= 3, 1);
        end

        // error response on m1 read
        resp_cfg = 1'b1;
        applyStimulus(1, 1, 0, 16'h0008, 32'h0, 4'hF);
        waitReady(1, 10, took);
        checkOutput("t5_m1_resp", m1_sib_resp, 1);
        checkOutput("t5_m1_rdata", m1_sib_rdata, 32'h0BADF00D);
        checkOutput("t5_m0_resp", m0_sib_resp, 0);
        @(posedge clk) #1 applyStimulus(1, 0, 0, 16'h0, 32'h0, 4'h0);
        resp_cfg = 1'b0;
        @(negedge clk);
        checkOutput("t5_resp_after", m1_sib_resp, 0);

        // reset in the middle of ACCESS
        wait_cfg = 5;
        @(posedge clk) #1 applyStimulus(0, 1, 0, 16'h0010, 32'h0, 4'hF);
        for (int i = 0; i < 10 && !s_sib_enable; i++) @(negedge clk);
        checkOutput("t6_in_access", s_sib_enable, 1);
        #1 reset = 1'b0;
        applyStimulus(0, 0, 0, 16'h0, 32'h0, 4'h0);
        #1;
        checkOutput("t6_rst_sel", s_sib_sel, 0);
        checkOutput("t6_rst_en", s_sib_enable, 0);
        checkOutput("t6_rst_owner", owner, 1);
        @(posedge clk) #1 reset = 1'b1;
        wait_cfg = 0;
        applyStimulus(0, 1, 0, 16'h0010, 32'h0, 4'hF);
        waitReady(0, 10, took);
        checkOutput("t6_latency", took, 2);
        checkOutput("t6_rdata", m0_sib_rdata, 32'hDEADBEEF);
        @(posedge clk) #1 applyStimulus(0, 0, 0, 16'h0, 32'h0, 4'h0);

        // owner drops sel during SETUP: transfer completes, no ready back
        wait_cfg = 2;
        @(posedge clk) #1 applyStimulus(0, 1, 0, 16'h0010, 32'h0, 4'hF);
        @(posedge clk) #1 applyStimulus(0, 0, 0, 16'h0, 32'h0, 4'h0);
        drop_rdy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m0_sib_ready) drop_rdy++;
        end
        checkOutput("t7_no_ready", drop_rdy, 0);
        checkOutput("t7_idle", busy, 0);
        wait_cfg = 0;

        // m0 write to address 0
        @(posedge clk) #1 applyStimulus(0, 1, 1, 16'h0000, 32'hA5A5A5A5, 4'hF);
        sel_seen = 1'b0;
        took = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (s_sib_sel) sel_seen = 1'b1;
            if (m0_sib_ready) begin
                took = i;
                checkOutput("t8_resp",
`ifdef IMEM_ARB_WRITE_PROTECT_EN
                            m0_sib_resp, 1);
`else
                            m0_sib_resp, 0);
`endif
                break;
            end
        end
        @(posedge clk) #1 applyStimulus(0, 0, 0, 16'h0, 32'h0, 4'h0);
`ifdef IMEM_ARB_WRITE_PROTECT_EN
        checkOutput("t8_latency", took, 1);
        checkOutput("t8_sel_seen", sel_seen, 0);
        checkOutput("t8_mem", mem[0], 32'h0);
`else
        checkOutput("t8_latency", took, 2);
        checkOutput("t8_sel_seen", sel_seen, 1);
        checkOutput("t8_mem", mem[0], 32'hA5A5A5A5);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
